// File: rtl/updn_counter_multi.sv
// updn_counter_multi: parametrised up/down counter with wrap, saturate and
// one-shot modes, registered terminal-count pulse and sticky saturation flag.
// Optional snapshot register guarded by macro COUNTER_SNAPSHOT_EN.
module updn_counter_multi #(
    parameter int WIDTH  = 8,
    parameter int LIMIT  = 2**WIDTH-1,
    parameter int STEP_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              Enable,
    input  logic              Load,
    input  logic              UpDn,
    input  logic [1:0]        Mode,
    input  logic [STEP_W-1:0] Step,
    input  logic [WIDTH-1:0]  Data,
    output logic [WIDTH-1:0]  Q,
    output logic              Tc,
    output logic              Sat,
    output logic              Busy,
    output logic              Done
`ifdef COUNTER_SNAPSHOT_EN
    ,
    input  logic              Snap,
    output logic [WIDTH-1:0]  SnapQ
`endif
);

    // Wide enough to compare Step against LIMIT whichever is wider.
    localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
    localparam logic [EW-1:0]    LIM_E  = EW'(LIMIT);
    localparam logic [WIDTH:0]   LIM_W1 = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   MOD_W1 = (WIDTH+1)'(LIMIT) + 1'b1;
    localparam logic [WIDTH-1:0] LIM_W  = WIDTH'(LIMIT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [EW-1:0]    step_e;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] q_cnt;
    logic [WIDTH-1:0] load_val;
    logic             hit;
    logic             oneshot, sat_mode, cnt_en;

    assign oneshot  = (Mode == 2'b10);
    assign sat_mode = (Mode == 2'b01);
    assign step_e   = EW'(Step);
    assign s        = (step_e > LIM_E) ? LIM_E[WIDTH-1:0] : step_e[WIDTH-1:0];
    assign sum      = {1'b0, Q} + {1'b0, s};
    assign load_val = ({1'b0, Data} > LIM_W1) ? LIM_W : Data;
    assign cnt_en   = Enable && (!oneshot || state == RUN);
    assign Busy     = (state == RUN);
    assign Done     = (state == DONE);

    // Next count value and whether this step wrapped, clamped or hit the bound.
    always_comb begin
        q_cnt = Q;
        hit   = 1'b0;
        if (s != '0) begin
            if (sat_mode || oneshot) begin
                if (UpDn) begin
                    if (sum >= LIM_W1) begin
                        q_cnt = LIM_W;
                        hit   = 1'b1;
                    end else begin
                        q_cnt = sum[WIDTH-1:0];
                    end
                end else begin
                    if (s >= Q) begin
                        q_cnt = '0;
                        hit   = 1'b1;
                    end else begin
                        q_cnt = Q - s;
                    end
                end
            end else begin
                // Wrap (and reserved mode): modulo LIMIT+1.
                if (UpDn) begin
                    if (sum > LIM_W1) begin
                        q_cnt = WIDTH'(sum - MOD_W1);
                        hit   = 1'b1;
                    end else begin
                        q_cnt = sum[WIDTH-1:0];
                        hit   = (sum == LIM_W1);
                    end
                end else begin
                    if (s > Q) begin
                        q_cnt = WIDTH'({1'b0, Q} + MOD_W1 - {1'b0, s});
                        hit   = 1'b1;
                    end else begin
                        q_cnt = Q - s;
                        hit   = (Q == s);
                    end
                end
            end
        end
    end

    // One-shot sequencer state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // One-shot next state: Clear/Load dominate, leaving one-shot mode idles it.
    always_comb begin
        state_nx = state;
        if (Clear) begin
            state_nx = IDLE;
        end else if (Load) begin
            state_nx = oneshot ? RUN : IDLE;
        end else if (!oneshot) begin
            state_nx = IDLE;
        end else begin
            case (state)
                RUN:     if (Enable && hit) state_nx = DONE;
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Count, saturation flag and terminal-count pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q   <= '0;
            Tc  <= 1'b0;
            Sat <= 1'b0;
        end else if (Clear) begin
            Q   <= '0;
            Tc  <= 1'b0;
            Sat <= 1'b0;
        end else if (Load) begin
            Q   <= load_val;
            Tc  <= 1'b0;
            Sat <= 1'b0;
        end else begin
            Tc <= cnt_en && hit;
            if (cnt_en) begin
                Q <= q_cnt;
                if (sat_mode && hit) Sat <= 1'b1;
            end
        end
    end

`ifdef COUNTER_SNAPSHOT_EN
    // Capture the pre-update count on Snap; unaffected by Clear/Load.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     SnapQ <= '0;
        else if (Snap) SnapQ <= Q;
    end
`else
    // Snapshot register not built.
`endif

endmodule
